time_preset_entry: RTL and testbench

User-side entry block for the stopwatch: the inverse path of the count-to-digits splitter. Buttons edit four BCD digits (n3 = most significant … n0). On confirm, the block serially converts the digits to a 14-bit binary preset and presents it to the count back-end with a one-cycle valid strobe. The edited digits are exported so the existing 7-segment decoders can show them while editing.

---
 rtl/time_preset_entry_pkg.sv | 7 +
 rtl/time_preset_entry_btn_conditioner.sv | 35 +++
 rtl/time_preset_entry.sv | 92 +++++++++
 tb/tb_time_preset_entry.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/time_preset_entry_pkg.sv
// time_preset_entry_pkg: shared FSM encoding and digit constants for the preset entry block
package time_preset_entry_pkg;
  typedef enum logic [1:0] {IDLE, EDIT, CONVERT, DONE} state_t;
  localparam logic [3:0] MAX_BCD = 4'd9;
  localparam logic [1:0] MSD = 2'd3;
  localparam logic [1:0] LSD = 2'd0;
endpackage

// File: rtl/time_preset_entry_btn_conditioner.sv
// time_preset_entry_btn_conditioner: polarity normalise, 2-FF sync, debounce and press pulse (clk, rst_n, btn raw pin -> press one-cycle event)
module time_preset_entry_btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic raw, s0, s1, level;
  logic [CW-1:0] cnt;
  assign raw = btn ^ BTN_ACTIVE_LOW;
  // level flips only after s1 has disagreed for DEBOUNCE_CYCLES consecutive cycles; agreement restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0    <= 1'b0;
      s1    <= 1'b0;
      level <= 1'b0;
      press <= 1'b0;
      cnt   <= '0;
    end else begin
      s0    <= raw;
      s1    <= s0;
      press <= 1'b0;
      if (s1 == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= s1;
        press <= s1;
        cnt   <= '0;
      end else cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/time_preset_entry.sv
// time_preset_entry: button-edited 4-digit BCD entry with serial BCD-to-binary preset conversion
// ports: clk, rst_n, btn_sel/inc/dec/ok raw pins; n3..n0 digits, edit_pos, editing, busy, preset_value, preset_valid strobe
import time_preset_entry_pkg::*;
module time_preset_entry #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit BTN_ACTIVE_LOW = 1'b1,
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_sel,
  input  logic             btn_inc,
  input  logic             btn_dec,
  input  logic             btn_ok,
  output logic [3:0]       n0,
  output logic [3:0]       n1,
  output logic [3:0]       n2,
  output logic [3:0]       n3,
  output logic [1:0]       edit_pos,
  output logic             editing,
  output logic             busy,
  output logic [WIDTH-1:0] preset_value,
  output logic             preset_valid
);
  logic [3:0] pins, ev;
  logic ev_sel, ev_inc, ev_dec, ev_ok;
  state_t state, state_nxt;
  logic [3:0] dig [4];
  logic [1:0] step;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [3:0] cur, cd;
  assign pins = {btn_ok, btn_dec, btn_inc, btn_sel};
  for (genvar i = 0; i < 4; i++) begin : g_btn
    time_preset_entry_btn_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_btn (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (pins[i]),
      .press(ev[i])
    );
  end
  assign {ev_ok, ev_dec, ev_inc, ev_sel} = ev;
  assign cur = dig[edit_pos];
  // step 0..3 walks n3 down to n0; acc*10 as shift-and-add
  assign cd = dig[MSD - step];
  assign acc_nxt = (acc << 3) + (acc << 1) + WIDTH'(cd);
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = ev_sel ? EDIT : IDLE;
      EDIT:    state_nxt = ev_ok ? CONVERT : EDIT;
      CONVERT: state_nxt = (step == 2'd3) ? DONE : CONVERT;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig          <= '{default: '0};
      edit_pos     <= MSD;
      acc          <= '0;
      step         <= '0;
      preset_value <= '0;
    end else begin
      case (state)
        IDLE: if (ev_sel) edit_pos <= MSD;
        EDIT:
          if (ev_ok) begin
            acc  <= '0;
            step <= '0;
          end else if (ev_sel) edit_pos <= edit_pos - 2'd1;
          else if (ev_inc && !ev_dec) dig[edit_pos] <= (cur == MAX_BCD) ? 4'd0 : cur + 4'd1;
          else if (ev_dec && !ev_inc) dig[edit_pos] <= (cur == 4'd0) ? MAX_BCD : cur - 4'd1;
        CONVERT: begin
          acc  <= acc_nxt;
          step <= step + 2'd1;
          if (step == 2'd3) preset_value <= acc_nxt;
        end
        default: edit_pos <= MSD;
      endcase
    end
  end
  assign {n3, n2, n1, n0} = {dig[3], dig[2], dig[1], dig[0]};
  assign editing      = (state == EDIT);
  assign busy         = (state == CONVERT);
  assign preset_valid = (state == DONE);
endmodule

// File: tb/tb_time_preset_entry.sv
// tb_time_preset_entry: directed stimulus with a behavioural reference model and literal spot checks
module tb_time_preset_entry;
  localparam int DB = 4;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] pin;
  logic [3:0] n0, n1, n2, n3;
  logic [1:0] edit_pos;
  logic editing, busy, preset_valid;
  logic [13:0] preset_value;
  int checks = 0, failures = 0;
  int m_mode, m_pos, m_cc, m_pre;
  int m_dig [4];
  bit m_lvl [4];
  bit m_ev [4];
  logic [7:0] m_hist [4];

  always #5 clk = ~clk;

  time_preset_entry #(.DEBOUNCE_CYCLES(DB), .BTN_ACTIVE_LOW(1'b1), .WIDTH(14)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_sel(pin[0]), .btn_inc(pin[1]), .btn_dec(pin[2]), .btn_ok(pin[3]),
    .n0(n0), .n1(n1), .n2(n2), .n3(n3), .edit_pos(edit_pos), .editing(editing),
    .busy(busy), .preset_value(preset_value), .preset_valid(preset_valid)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // reference: a button is accepted once its synchronised (2-cycle delayed) pressed state has
  // disagreed with the accepted state for DB samples in a row; the FSM acts on that event next cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_pos = 3; m_cc = 0; m_pre = 0;
      for (int b = 0; b < 4; b++) begin
        m_dig[b] = 0; m_lvl[b] = 0; m_ev[b] = 0; m_hist[b] = '0;
      end
    end else begin
      case (m_mode)
        0: if (m_ev[0]) begin m_mode = 1; m_pos = 3; end
        1: if (m_ev[3]) begin m_mode = 2; m_cc = 0; end
           else if (m_ev[0]) m_pos = (m_pos + 3) % 4;
           else if (m_ev[1] && !m_ev[2]) m_dig[m_pos] = (m_dig[m_pos] + 1) % 10;
           else if (m_ev[2] && !m_ev[1]) m_dig[m_pos] = (m_dig[m_pos] + 9) % 10;
        2: begin
          m_cc++;
          if (m_cc == 4) begin
            m_mode = 3;
            m_pre = 1000 * m_dig[3] + 100 * m_dig[2] + 10 * m_dig[1] + m_dig[0];
          end
        end
        default: begin m_mode = 0; m_pos = 3; end
      endcase
      for (int b = 0; b < 4; b++) begin
        bit all_diff;
        all_diff = 1;
        for (int i = 1; i <= DB; i++) if (m_hist[b][i] == m_lvl[b]) all_diff = 0;
        m_ev[b] = all_diff && !m_lvl[b];
        if (all_diff) m_lvl[b] = !m_lvl[b];
        m_hist[b] = {m_hist[b][6:0], ~pin[b]};
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_n0", n0, m_dig[0]);
    chk("cyc_n1", n1, m_dig[1]);
    chk("cyc_n2", n2, m_dig[2]);
    chk("cyc_n3", n3, m_dig[3]);
    chk("cyc_edit_pos", edit_pos, m_pos);
    chk("cyc_editing", editing, m_mode == 1);
    chk("cyc_busy", busy, m_mode == 2);
    chk("cyc_preset_valid", preset_valid, m_mode == 3);
    chk("cyc_preset_value", preset_value, m_pre);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] m, input int times);
    repeat (times) begin
      pin = pin & ~m;
      tick(8);
      pin = 4'hF;
      tick(8);
    end
  endtask

  // presses m at once and late two cycles later, then tallies busy/valid cycles
  task automatic do_ok(input logic [3:0] m, input logic [3:0] late, input int exp, output int pb);
    int nb, nv, pv;
    nb = 0; nv = 0; pv = -1; pb = -1;
    pin = pin & ~m;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (i == 2) pin = pin & ~late;
      if (i == 12) pin = 4'hF;
      if (busy) begin
        nb++;
        if (pb < 0) pb = edit_pos;
      end
      if (preset_valid) begin
        nv++;
        pv = preset_value;
      end
    end
    chk("busy_cycles", nb, 4);
    chk("valid_cycles", nv, 1);
    chk("preset_literal", pv, exp);
    chk("pos_after_done", edit_pos, 3);
  endtask

  initial begin
    int pb, nv;
    int exp_pos [4] = '{2, 1, 0, 3};
    pin = 4'hF;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    chk("rst_edit_pos", edit_pos, 3);
    chk("rst_editing", editing, 0);
    chk("rst_preset", preset_value, 0);
    // bouncing sel interrupted by an asynchronous reset
    for (int i = 0; i < 6; i++) begin
      pin[0] = ~pin[0];
      tick(1);
    end
    pin[0] = 1'b0;
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_digits", {n3, n2, n1, n0}, 0);
    chk("async_edit_pos", edit_pos, 3);
    chk("async_flags", {editing, busy, preset_valid}, 0);
    pin = 4'hF;
    tick(3);
    rst_n = 1'b1;
    tick(16);
    chk("no_stray_event", editing, 0);
    press(4'b0001, 1);
    chk("sel_editing", editing, 1);
    chk("sel_pos", edit_pos, 3);
    // bouncing inc then a clean hold: one increment
    for (int i = 0; i < 5; i++) begin
      pin[1] = 1'b0; tick(2);
      pin[1] = 1'b1; tick(2);
    end
    pin[1] = 1'b0; tick(10);
    pin[1] = 1'b1; tick(8);
    chk("bounce_one_inc", n3, 1);
    pin[1] = 1'b0; tick(3);
    pin[1] = 1'b1; tick(10);
    chk("glitch_ignored", n3, 1);
    press(4'b0100, 1);
    chk("dec_to_0", n3, 0);
    press(4'b0100, 1);
    chk("dec_wrap_9", n3, 9);
    press(4'b0010, 1);
    chk("inc_wrap_0", n3, 0);
    for (int i = 0; i < 4; i++) begin
      press(4'b0001, 1);
      chk("sel_walk", edit_pos, exp_pos[i]);
    end
    press(4'b0001, 3);
    chk("pos0", edit_pos, 0);
    press(4'b0010, 10);
    chk("n0_ten_inc", n0, 0);
    // 9999
    press(4'b0100, 1);
    for (int i = 0; i < 3; i++) begin
      press(4'b0001, 1);
      press(4'b0100, 1);
    end
    chk("digits_9999", {n3, n2, n1, n0}, 16'h9999);
    do_ok(4'b1000, 4'b0000, 9999, pb);
    chk("idle_after_done", editing, 0);
    // 0407
    press(4'b0001, 1);
    press(4'b0010, 1);
    press(4'b0001, 1);
    press(4'b0010, 5);
    press(4'b0001, 1);
    press(4'b0010, 1);
    press(4'b0001, 1);
    press(4'b0100, 2);
    chk("digits_0407", {n3, n2, n1, n0}, 16'h0407);
    do_ok(4'b1000, 4'b0000, 407, pb);
    // 0000
    press(4'b0001, 2);
    press(4'b0100, 4);
    press(4'b0001, 2);
    press(4'b0010, 3);
    chk("digits_0000", {n3, n2, n1, n0}, 16'h0000);
    do_ok(4'b1000, 4'b0000, 0, pb);
    chk("digits_retained", {n3, n2, n1, n0}, 16'h0000);
    // ok and sel together: ok wins, position stays
    press(4'b0001, 2);
    press(4'b0010, 1);
    do_ok(4'b1001, 4'b0000, 100, pb);
    chk("ok_sel_pos", pb, 2);
    press(4'b0001, 1);
    press(4'b0110, 1);
    chk("inc_dec_nochange", n3, 0);
    do_ok(4'b1000, 4'b0010, 100, pb);
    chk("busy_drop", {n3, n2, n1, n0}, 16'h0100);
    // reset on the second busy cycle
    press(4'b0001, 1);
    pin[3] = 1'b0;
    for (int i = 0; i < 20 && !busy; i++) tick(1);
    chk("t6_busy_seen", busy, 1);
    tick(1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_preset_zero", preset_value, 0);
    chk("t6_busy_low", busy, 0);
    pin = 4'hF;
    tick(3);
    rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      nv += preset_valid;
    end
    chk("t6_no_valid", nv, 0);
    chk("t6_digits", {n3, n2, n1, n0}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
